bp_network_deserializer: RTL and testbench
==========================================

Name: bp_network_deserializer

Overview:
- Downstream stage of the network serializer; consumes its flit stream.
- Each flit is {dest_id, packet payload}. The block reassembles a fixed count of flits into the original wide message.
- It then presents the message, plus the dest id, to the consuming endpoint (coherence/memory side) over a valid/yumi interface.
- It checks that all flits of one message carry the same dest id.

Parameters:
- dest_id_width_p, 4, width of dest id field carried in each flit's top bits
- data_width_p, 64, width of the reassembled message (the serializer's source width)
- packet_data_width_p, 16, payload bits per flit
- num_packets_lp (localparam), data_width_p/packet_data_width_p + 1, flits per message; identical to the serializer's count (64/16 gives 5)
- flit_width_lp (localparam), packet_data_width_p + dest_id_width_p (20 by default)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- valid_i  in  1  flit valid
- data_i  in  flit_width_lp  flit: [flit_width_lp-1 -: dest_id_width_p] dest id, [0 +: packet_data_width_p] payload
- ready_o  out  1  block can accept a flit this cycle
- valid_o  out  1  reassembled message available
- data_o  out  data_width_p  reassembled message
- dest_id_o  out  dest_id_width_p  dest id latched from the message's first flit
- yumi_i  in  1  consumer takes the message; legal only when valid_o=1
- mismatch_o  out  1  sticky: a flit's dest id differed from its message's first flit

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is synchronous and active-high.
- Reset values:
  - state=eRECV, count=0, buffer=0.
  - valid_o=0, data_o=0, dest_id_o=0, mismatch_o=0.
  - ready_o=0 while reset_i=1.
- Flit accept: occurs when valid_i & ready_o.
- Flit ordering:
  - Flit k (k=0 first) payload is written to buffer[k*packet_data_width_p +: packet_data_width_p].
  - Lowest slice arrives first, matching serial-out order.
- Output mapping:
  - data_o = buffer[data_width_p-1:0].
  - Padding bits above data_width_p are discarded.
- FSM states:
  - eRECV: ready_o=1, valid_o=0.
    - On accept with count<num_packets_lp-1: store payload, count++.
    - On accept with count==0: also latch dest_id_o.
    - On accept with count==num_packets_lp-1: store payload, count<=0, go to eFULL next cycle.
  - eFULL: valid_o=1; data_o and dest_id_o are held stable until yumi_i.
    - ready_o = yumi_i (combinational pass of yumi_i), which allows a back-to-back first flit.
    - On yumi_i without accept: go to eRECV.
    - On yumi_i with accept (new first flit): store it at slice 0, latch new dest_id_o, count<=1, go to eRECV.
- Latency and throughput:
  - valid_o rises the cycle after the last flit is accepted.
  - Sustained throughput: one message per num_packets_lp cycles when yumi_i returns the same cycle valid_o rises.
- Mismatch check:
  - An accepted flit with count!=0 whose dest id differs from dest_id_o sets mismatch_o=1.
  - mismatch_o is cleared only by reset; the payload is still stored.
- Protocol errors:
  - yumi_i in eRECV and valid_i while in eFULL without yumi_i are ignored; no state change.
- Reset mid-message: partial count and buffer are discarded; the next accepted flit is treated as flit 0.
- valid_o does not depend combinationally on valid_i or yumi_i.

Test Plan:
- Single message: 5 flits, dest 0x3, payloads 0x1111,0x2222,0x3333,0x4444,0x0003 -> valid_o=1 on the cycle after flit 5; data_o=0x4444_3333_2222_1111; dest_id_o=0x3; mismatch_o=0.
- Consumer stall: hold yumi_i=0 for 10 cycles after valid_o -> ready_o=0, data_o stable, extra flits refused (count unchanged); yumi_i=1 -> valid_o=0 next cycle.
- Back-to-back: yumi_i asserted the same cycle as the first flit of message 2 (dest 0x5) -> flit accepted, dest_id_o=0x5, message 2 valid exactly 5 cycles later.
- Dest mismatch: flit 3 carries dest 0x7 in a dest 0x3 message -> mismatch_o=1 from the next cycle and stays 1 through later messages; data still assembled.
- Reset after 2 flits: then a full 5-flit message with payloads 0xA..0xE -> data_o reflects only the new flits, slice 0 = 0x000A.
- Random valid_i/yumi_i gaps over 1000 messages vs. a serializer model -> every data_o/dest_id_o matches, no loss or duplication.

Source files
------------

// File: rtl/bp_network_deserializer.sv
// Reassembles a fixed number of {dest_id, payload} flits into one wide message
// and hands it to the endpoint over valid/yumi, flagging inconsistent dest ids.
module bp_network_deserializer #(
  parameter int dest_id_width_p     = 4,
  parameter int data_width_p        = 64,
  parameter int packet_data_width_p = 16,
  localparam int num_packets_lp     = data_width_p / packet_data_width_p + 1,
  localparam int flit_width_lp      = packet_data_width_p + dest_id_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic [flit_width_lp-1:0]   data_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [data_width_p-1:0]    data_o,
  output logic [dest_id_width_p-1:0] dest_id_o,
  input  logic                       yumi_i,
  output logic                       mismatch_o
);

  localparam int count_width_lp = (num_packets_lp > 1) ? $clog2(num_packets_lp) : 1;
  localparam logic [count_width_lp-1:0] last_count_lp = count_width_lp'(num_packets_lp - 1);

  typedef enum logic {eRECV, eFULL} state_e;

  state_e                      state_q;
  logic [count_width_lp-1:0]   count_q;
  logic [dest_id_width_p-1:0]  dest_id_q;
  logic                        valid_q;
  logic                        mismatch_q;

  logic [dest_id_width_p-1:0]     flit_dest;
  logic [packet_data_width_p-1:0] flit_payload;
  logic                           accept;
  logic [count_width_lp-1:0]      slot;

  assign flit_dest    = data_i[flit_width_lp-1 -: dest_id_width_p];
  assign flit_payload = data_i[0 +: packet_data_width_p];

  // In eFULL a flit is only taken alongside yumi, which lets the next message start back-to-back.
  assign ready_o = ~reset_i & ((state_q == eRECV) | yumi_i);
  assign accept  = valid_i & ready_o;
  assign slot    = (state_q == eFULL) ? '0 : count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= eRECV;
      count_q    <= '0;
      dest_id_q  <= '0;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      case (state_q)
        eRECV: begin
          if (accept) begin
            if (count_q == '0) begin
              dest_id_q <= flit_dest;
            end else if (flit_dest != dest_id_q) begin
              mismatch_q <= 1'b1;
            end
            if (count_q == last_count_lp) begin
              count_q <= '0;
              state_q <= eFULL;
              valid_q <= 1'b1;
            end else begin
              count_q <= count_q + count_width_lp'(1);
            end
          end
        end
        eFULL: begin
          if (yumi_i) begin
            state_q <= eRECV;
            valid_q <= 1'b0;
            if (accept) begin
              dest_id_q <= flit_dest;
              count_q   <= count_width_lp'(1);
            end
          end
        end
        default: begin
          state_q <= eRECV;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Slices that fall entirely in the padding above data_width_p are never stored.
  for (genvar gi = 0; gi < num_packets_lp; gi++) begin : g_slice
    localparam int lo_lp = gi * packet_data_width_p;
    if (lo_lp < data_width_p) begin : g_store
      localparam int w_lp = ((data_width_p - lo_lp) < packet_data_width_p)
                            ? (data_width_p - lo_lp) : packet_data_width_p;
      logic [w_lp-1:0] slice_q;
      logic            slice_we;

      assign slice_we = accept & (slot == count_width_lp'(gi));

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          slice_q <= '0;
        end else if (slice_we) begin
          slice_q <= flit_payload[w_lp-1:0];
        end
      end

      assign data_o[lo_lp +: w_lp] = slice_q;
    end
  end

  assign valid_o    = valid_q;
  assign dest_id_o  = dest_id_q;
  assign mismatch_o = mismatch_q;

endmodule

// File: tb/tb_bp_network_deserializer.sv
// Directed and randomised checks of flit reassembly, stall, back-to-back,
// dest-id mismatch and mid-message reset behaviour.
module tb_bp_network_deserializer;

  localparam int DW = 4;
  localparam int FW = 20;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic [FW-1:0] data_i;
  logic          ready_o;
  logic          valid_o;
  logic [63:0]   data_o;
  logic [DW-1:0] dest_id_o;
  logic          yumi_i;
  logic          mismatch_o;

  int errors = 0;
  int checks = 0;

  bp_network_deserializer dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .dest_id_o  (dest_id_o),
    .yumi_i     (yumi_i),
    .mismatch_o (mismatch_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input logic [3:0] d, input logic [15:0] p);
    valid_i = 1'b1;
    data_i  = {d, p};
    tick();
    valid_i = 1'b0;
  endtask

  task automatic consume();
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
  endtask

  logic [67:0] exp_q[$];
  logic [67:0] exp_item;
  logic [15:0] cur_p[5];
  logic [3:0]  cur_d;

  initial begin
    int sent_msgs, recv, flit_k, cycles;
    bit have_msg;

    reset_i = 1'b1;
    valid_i = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;
    tick();
    tick();
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_dest", dest_id_o, 0);
    check("rst_mismatch", mismatch_o, 0);
    check("rst_ready", ready_o, 0);
    reset_i = 1'b0;
    #1;
    check("ready_after_rst", ready_o, 1);

    // single message
    push_flit(4'h3, 16'h1111);
    push_flit(4'h3, 16'h2222);
    push_flit(4'h3, 16'h3333);
    push_flit(4'h3, 16'h4444);
    check("single_no_early_valid", valid_o, 0);
    push_flit(4'h3, 16'h0003);
    check("single_valid", valid_o, 1);
    check("single_data", data_o, 64'h4444_3333_2222_1111);
    check("single_dest", dest_id_o, 4'h3);
    check("single_mismatch", mismatch_o, 0);

    // consumer stall with offered flits that must be refused
    valid_i = 1'b1;
    data_i  = {4'h9, 16'hDEAD};
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_ready", ready_o, 0);
      tick();
    end
    valid_i = 1'b0;
    check("stall_valid", valid_o, 1);
    check("stall_data", data_o, 64'h4444_3333_2222_1111);
    check("stall_dest", dest_id_o, 4'h3);
    yumi_i = 1'b1;
    #1;
    check("yumi_ready", ready_o, 1);
    tick();
    yumi_i = 1'b0;
    check("yumi_drop_valid", valid_o, 0);

    // back-to-back: first flit of message 2 with yumi of message 1
    push_flit(4'h3, 16'hA1A1);
    push_flit(4'h3, 16'hA2A2);
    push_flit(4'h3, 16'hA3A3);
    push_flit(4'h3, 16'hA4A4);
    push_flit(4'h3, 16'h0000);
    check("b2b_first_valid", valid_o, 1);
    check("b2b_first_data", data_o, 64'hA4A4_A3A3_A2A2_A1A1);
    yumi_i  = 1'b1;
    valid_i = 1'b1;
    data_i  = {4'h5, 16'h5000};
    #1;
    check("b2b_ready", ready_o, 1);
    tick();
    yumi_i  = 1'b0;
    valid_i = 1'b0;
    check("b2b_valid_low", valid_o, 0);
    check("b2b_dest", dest_id_o, 4'h5);
    push_flit(4'h5, 16'h5001);
    push_flit(4'h5, 16'h5002);
    push_flit(4'h5, 16'h5003);
    check("b2b_no_early_valid", valid_o, 0);
    push_flit(4'h5, 16'h0005);
    check("b2b_second_valid", valid_o, 1);
    check("b2b_second_data", data_o, 64'h5003_5002_5001_5000);
    check("b2b_second_dest", dest_id_o, 4'h5);
    consume();

    // dest mismatch on the third flit
    push_flit(4'h3, 16'h0101);
    push_flit(4'h3, 16'h0202);
    check("mm_before", mismatch_o, 0);
    push_flit(4'h7, 16'h0303);
    check("mm_set", mismatch_o, 1);
    push_flit(4'h3, 16'h0404);
    push_flit(4'h3, 16'h0003);
    check("mm_valid", valid_o, 1);
    check("mm_data", data_o, 64'h0404_0303_0202_0101);
    check("mm_dest", dest_id_o, 4'h3);
    consume();
    push_flit(4'h1, 16'h1001);
    push_flit(4'h1, 16'h1002);
    push_flit(4'h1, 16'h1003);
    push_flit(4'h1, 16'h1004);
    push_flit(4'h1, 16'h1005);
    check("mm_sticky", mismatch_o, 1);
    check("mm_next_data", data_o, 64'h1004_1003_1002_1001);
    consume();

    // reset after two flits
    push_flit(4'h6, 16'hBEEF);
    push_flit(4'h6, 16'hCAFE);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("midrst_valid", valid_o, 0);
    check("midrst_mismatch", mismatch_o, 0);
    push_flit(4'h2, 16'h000A);
    push_flit(4'h2, 16'h000B);
    push_flit(4'h2, 16'h000C);
    push_flit(4'h2, 16'h000D);
    push_flit(4'h2, 16'h000E);
    check("midrst_valid_after", valid_o, 1);
    check("midrst_data", data_o, 64'h000D_000C_000B_000A);
    check("midrst_dest", dest_id_o, 4'h2);
    consume();

    // random gaps against a serializer model
    sent_msgs = 0;
    recv      = 0;
    flit_k    = 0;
    cycles    = 0;
    have_msg  = 1'b0;
    while (recv < 1000 && cycles < 40000) begin
      cycles++;
      if (!have_msg && sent_msgs < 1000) begin
        cur_d = 4'($urandom);
        for (int k = 0; k < 5; k++) cur_p[k] = 16'($urandom);
        exp_q.push_back({cur_d, cur_p[3], cur_p[2], cur_p[1], cur_p[0]});
        have_msg = 1'b1;
        flit_k   = 0;
      end
      valid_i = have_msg && ($urandom_range(0, 3) != 0);
      data_i  = {cur_d, cur_p[flit_k]};
      yumi_i  = valid_o && ($urandom_range(0, 2) != 0);
      #1;
      if (yumi_i) begin
        if (exp_q.size() == 0) begin
          check("rand_extra_msg", 1, 0);
        end else begin
          exp_item = exp_q.pop_front();
          check("rand_data", data_o, exp_item[63:0]);
          check("rand_dest", dest_id_o, exp_item[67:64]);
        end
        recv++;
      end
      if (valid_i && ready_o) begin
        flit_k++;
        if (flit_k == 5) begin
          flit_k   = 0;
          have_msg = 1'b0;
          sent_msgs++;
        end
      end
      tick();
    end
    valid_i = 1'b0;
    yumi_i  = 1'b0;
    check("rand_recv_count", recv, 1000);
    check("rand_sent_count", sent_msgs, 1000);
    check("rand_leftover", exp_q.size(), 0);
    check("rand_mismatch", mismatch_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
